ablk_ctrl: RTL

- Digital controller that sits directly upstream of the analog block and generates all of its inputs: ABLK_PG, ABLK_RESETn, ABLK_EN, ABLK_CONFIG_0 and ABLK_CONFIG_1.
- Takes register writes from the MBus layer-controller register interface.
- Sequences analog power-up and power-down with programmable inter-step delays.
- Holds configuration in a shadow register and applies it to the analog block only in stable states (OFF or ON).

---
 rtl/ablk_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ablk_ctrl.sv
// Analog block power sequencer: MBus register writes, shadowed config, timed PG/RESETn/EN steps.
// Optional auto-off timeout in ON, enabled by defining ABLK_CTRL_TIMEOUT_EN.
module ablk_ctrl #(
    parameter logic [7:0]  CTRL_ADDR   = 8'h10,
    parameter logic [7:0]  CFG_ADDR    = 8'h11,
    parameter int unsigned DLY_W       = 8,
    parameter int unsigned PG_DLY      = 8,
    parameter int unsigned RST_DLY     = 4,
    parameter int unsigned EN_DLY      = 2
`ifdef ABLK_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        REG_WR_REQ,
    input  logic [7:0]  REG_WR_ADDR,
    input  logic [23:0] REG_WR_DATA,
    output logic        REG_WR_ACK,
    output logic        ABLK_PG,
    output logic        ABLK_RESETn,
    output logic        ABLK_EN,
    output logic [3:0]  ABLK_CONFIG_0,
    output logic [3:0]  ABLK_CONFIG_1,
    output logic        ABLK_ON,
    output logic        ABLK_BUSY
);

    // A programmed delay of zero still spends one cycle in its wait state.
    localparam logic [DLY_W-1:0] PG_LOAD  = (PG_DLY  == 0) ? DLY_W'(1) : DLY_W'(PG_DLY);
    localparam logic [DLY_W-1:0] RST_LOAD = (RST_DLY == 0) ? DLY_W'(1) : DLY_W'(RST_DLY);
    localparam logic [DLY_W-1:0] EN_LOAD  = (EN_DLY  == 0) ? DLY_W'(1) : DLY_W'(EN_DLY);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_PG_WAIT  = 3'd1,
        S_RST_WAIT = 3'd2,
        S_ON       = 3'd3,
        S_EN_WAIT  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DLY_W-1:0]  cnt, cnt_nxt;
    logic              target;
    logic              target_eff;
    logic              to_hit;
    logic [3:0]        shadow_0, shadow_1;
    logic              wr_fire, ctrl_wr, cfg_wr;
    logic              stable;
    logic              pg_nxt, rstn_nxt, en_nxt, busy_nxt, on_nxt;
    logic              unused_data;

    assign unused_data = ^REG_WR_DATA[23:8];

    assign wr_fire = REG_WR_REQ && !REG_WR_ACK;
    assign ctrl_wr = wr_fire && (REG_WR_ADDR == CTRL_ADDR);
    assign cfg_wr  = wr_fire && (REG_WR_ADDR == CFG_ADDR);
    assign stable  = (state == S_OFF) || (state == S_ON);

    // Four-phase acknowledge: one register update per request.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            REG_WR_ACK <= 1'b0;
        end else if (wr_fire) begin
            REG_WR_ACK <= 1'b1;
        end else if (!REG_WR_REQ) begin
            REG_WR_ACK <= 1'b0;
        end
    end

`ifdef ABLK_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state == S_ON) && !ctrl_wr && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Counts ON cycles since ON entry or the latest control write.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            to_cnt <= '0;
        end else if ((state != S_ON) || ctrl_wr) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign target_eff = target && !to_hit;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            target <= 1'b0;
        end else if (ctrl_wr) begin
            target <= REG_WR_DATA[0];
        end else if (to_hit) begin
            target <= 1'b0;
        end
    end

    // Config reaches the analog block only while it is in a stable state.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            shadow_0      <= '0;
            shadow_1      <= '0;
            ABLK_CONFIG_0 <= '0;
            ABLK_CONFIG_1 <= '0;
        end else begin
            if (cfg_wr) begin
                shadow_0 <= REG_WR_DATA[3:0];
                shadow_1 <= REG_WR_DATA[7:4];
            end
            if (stable) begin
                ABLK_CONFIG_0 <= shadow_0;
                ABLK_CONFIG_1 <= shadow_1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_OFF: begin
                if (target_eff) begin
                    state_nxt = S_PG_WAIT;
                    cnt_nxt   = PG_LOAD;
                end
            end
            S_PG_WAIT: begin
                if (cnt <= DLY_W'(1)) begin
                    state_nxt = S_RST_WAIT;
                    cnt_nxt   = RST_LOAD;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            S_RST_WAIT: begin
                if (cnt <= DLY_W'(1)) begin
                    state_nxt = S_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            S_ON: begin
                if (!target_eff) begin
                    state_nxt = S_EN_WAIT;
                    cnt_nxt   = EN_LOAD;
                end
            end
            S_EN_WAIT: begin
                if (cnt <= DLY_W'(1)) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            default: begin
                state_nxt = S_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decode from the next state so the registered outputs change on the entry edge.
    always_comb begin
        pg_nxt   = 1'b1;
        rstn_nxt = 1'b0;
        en_nxt   = 1'b0;
        busy_nxt = 1'b0;
        on_nxt   = 1'b0;
        case (state_nxt)
            S_PG_WAIT: begin
                pg_nxt   = 1'b0;
                busy_nxt = 1'b1;
            end
            S_RST_WAIT, S_EN_WAIT: begin
                pg_nxt   = 1'b0;
                rstn_nxt = 1'b1;
                busy_nxt = 1'b1;
            end
            S_ON: begin
                pg_nxt   = 1'b0;
                rstn_nxt = 1'b1;
                en_nxt   = 1'b1;
                on_nxt   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ABLK_PG     <= 1'b1;
            ABLK_RESETn <= 1'b0;
            ABLK_EN     <= 1'b0;
            ABLK_BUSY   <= 1'b0;
            ABLK_ON     <= 1'b0;
        end else begin
            ABLK_PG     <= pg_nxt;
            ABLK_RESETn <= rstn_nxt;
            ABLK_EN     <= en_nxt;
            ABLK_BUSY   <= busy_nxt;
            ABLK_ON     <= on_nxt;
        end
    end

endmodule
